// File: rtl/fc_argmax.sv
// fc_argmax -- argmax over the fully-connected layer's output cells.
//
// After the FC layer has written its signed 16-bit outputs to the shared
// activation memory, a start pulse makes this block read NUM_CLASS words
// from BASE_ADDR upward (one per cycle). It keeps a running maximum and
// reports the winning index with a one-cycle done pulse.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      begin a scan (ignored unless idle)
//   rd_data    signed read data, valid RD_LAT cycles after rd_en
//   rd_en      memory read strobe
//   rd_addr    memory read address (0 whenever rd_en is low)
//   class_idx  index of the maximum (held until the next done)
//   max_value  signed maximum (held until the next done)
//   busy       high from the cycle after start through the done cycle
//   done       one-cycle result-valid pulse
//
// Configuration macro:
//   ARGMAX_TIE_LAST_EN  defined: ties resolve to the highest index (>=)
//                       undefined: ties resolve to the lowest index (>)
module fc_argmax #(
  parameter int NUM_CLASS = 5,   // 1..256
  parameter int BASE_ADDR = 1,
  parameter int RD_LAT    = 1    // 1..3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] rd_data,
  output logic               rd_en,
  output logic [15:0]        rd_addr,
  output logic [7:0]         class_idx,
  output logic signed [15:0] max_value,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam logic [8:0] LAST_ISSUE = 9'(NUM_CLASS - 1);
  localparam logic [8:0] NCLS       = 9'(NUM_CLASS);

  state_e             state_q, state_d;
  logic [8:0]         issue_q, issue_d;   // reads issued so far
  logic [8:0]         cap_q, cap_d;       // words captured so far
  logic signed [15:0] run_max_q, run_max_d;
  logic [7:0]         run_idx_q, run_idx_d;
  logic signed [15:0] max_q, max_d;
  logic [7:0]         idx_q, idx_d;
  logic [RD_LAT-1:0]  vld_q;              // in-flight read tracker
  logic               cap_vld, better, take;

  assign cap_vld = vld_q[RD_LAT-1];

`ifdef ARGMAX_TIE_LAST_EN
  assign better = (rd_data >= run_max_q);
`else
  assign better = (rd_data > run_max_q);
`endif

  // The first word always loads, so a lone 16'sh8000 still reports index 0.
  assign take = cap_vld && ((cap_q == 9'd0) || better);

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    max_d     = max_q;
    idx_d     = idx_q;
    rd_en     = 1'b0;
    rd_addr   = 16'd0;

    if (cap_vld) begin
      cap_d = cap_q + 9'd1;
      if (take) begin
        run_max_d = rd_data;
        run_idx_d = cap_q[7:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READ;
          issue_d   = 9'd0;
          cap_d     = 9'd0;
          run_max_d = 16'sh8000;
          run_idx_d = 8'd0;
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = 16'(BASE_ADDR) + {7'd0, issue_q};
        issue_d = issue_q + 9'd1;
        if (issue_q == LAST_ISSUE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Publish on the final capture so results are already on the
        // outputs during the done cycle.
        if (cap_d == NCLS) begin
          state_d = S_DONE;
          max_d   = run_max_d;
          idx_d   = run_idx_d;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      issue_q   <= 9'd0;
      cap_q     <= 9'd0;
      run_max_q <= 16'sh8000;
      run_idx_q <= 8'd0;
      max_q     <= 16'sh0000;
      idx_q     <= 8'd0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      vld_q[0]  <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign class_idx = idx_q;
  assign max_value = max_q;

endmodule
